// File: rtl/instruction_fetch_controller_if.sv
// Fetch-side bundle: ROM address/data, decode valid/ready handshake, redirect and fault.
interface instruction_fetch_controller_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] pm_address_o;
   logic [DATA_WIDTH-1:0] pm_instruction_i;
   logic [DATA_WIDTH-1:0] instr_o;
   logic [DATA_WIDTH-1:0] pc_o;
   logic                  instr_valid_o;
   logic                  instr_ready_i;
   logic                  redirect_i;
   logic [DATA_WIDTH-1:0] redirect_pc_i;
   logic                  fault_o;

   // Fetch controller side.
   modport master (
      output pm_address_o,
      input  pm_instruction_i,
      output instr_o,
      output pc_o,
      output instr_valid_o,
      input  instr_ready_i,
      input  redirect_i,
      input  redirect_pc_i,
      output fault_o
   );

   // ROM / decode / branch-logic side.
   modport slave (
      input  pm_address_o,
      output pm_instruction_i,
      input  instr_o,
      input  pc_o,
      input  instr_valid_o,
      output instr_ready_i,
      output redirect_i,
      output redirect_pc_i,
      input  fault_o
   );
endinterface

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: drives the ROM address from the fetch PC, buffers
// {pc, instruction} pairs in a 2-entry FIFO (slot 0 is always the head) and hands them to
// decode over valid/ready. Redirect flushes the FIFO; bad fetch addresses halt fetching.
module instruction_fetch_controller #(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           MEMORY_DEPTH = 32,
   parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000,
   parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000
) (
   input logic                          clk,
   input logic                          reset,
   instruction_fetch_controller_if.master bus
);

   localparam logic [DATA_WIDTH-1:0] RomBytes = DATA_WIDTH'(MEMORY_DEPTH * 4);

   typedef enum logic [1:0] {StStart, StRun, StHalt} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]            count_q, count_d;
   logic                  fault_q, fault_d;
   logic [DATA_WIDTH-1:0] instr_q [2];
   logic [DATA_WIDTH-1:0] instr_d [2];
   logic [DATA_WIDTH-1:0] pc_q    [2];
   logic [DATA_WIDTH-1:0] pc_d    [2];

   logic [DATA_WIDTH-1:0] fetch_offset;
   logic                  addr_ok;
   logic                  pop;
   logic                  space;
   logic                  push;
   logic                  pop_en;
   logic                  flush;
   logic                  fault_hit;
   logic [1:0]            tail;

   // Unsigned compare also rejects PCs below TEXT_BASE, since the offset wraps large.
   assign fetch_offset = fetch_pc_q - TEXT_BASE;
   assign addr_ok      = (fetch_pc_q[1:0] == 2'b00) && (fetch_offset < RomBytes);
   assign pop          = (count_q != 2'd0) && bus.instr_ready_i;
   assign space        = (count_q < 2'd2) || pop;

   assign bus.pm_address_o  = fetch_offset;
   assign bus.instr_o       = instr_q[0];
   assign bus.pc_o          = pc_q[0];
   assign bus.instr_valid_o = (count_q != 2'd0);
   assign bus.fault_o       = fault_q;

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StStart;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: redirect leaves HALT (and wins over a fault in RUN); START lasts one cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StStart: state_d = StRun;
         StRun:   state_d = (!bus.redirect_i && fault_hit) ? StHalt : StRun;
         StHalt:  state_d = bus.redirect_i ? StRun : StHalt;
         default: state_d = StStart;
      endcase
   end

   // FSM outputs: per-cycle flush / push / fault decisions.
   always_comb begin
      flush     = 1'b0;
      push      = 1'b0;
      fault_hit = 1'b0;
      unique case (state_q)
         StStart: ;
         StRun: begin
            if (bus.redirect_i) begin
               flush = 1'b1;
            end else if (space) begin
               push      = addr_ok;
               fault_hit = !addr_ok;
            end
         end
         StHalt:  flush = bus.redirect_i;
         default: ;
      endcase
      pop_en = pop && !flush;
   end

   // Datapath next state: shift head out on pop, write tail on push, advance fetch PC.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      fault_d    = fault_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      tail       = count_q - {1'b0, pop_en};
      if (flush) begin
         count_d    = 2'd0;
         fetch_pc_d = bus.redirect_pc_i;
         fault_d    = 1'b0;
      end else begin
         if (pop_en) begin
            instr_d[0] = instr_q[1];
            pc_d[0]    = pc_q[1];
         end
         if (push) begin
            instr_d[tail[0]] = bus.pm_instruction_i;
            pc_d[tail[0]]    = fetch_pc_q;
            fetch_pc_d       = fetch_pc_q + DATA_WIDTH'(4);
         end
         count_d = tail + {1'b0, push};
         if (fault_hit) begin
            fault_d = 1'b1;
         end
      end
   end

   // Datapath registers; reset clears FIFO contents, fault and fetch PC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= 2'd0;
         fault_q    <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         fault_q    <= fault_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Randomized scoreboard bench for instruction_fetch_controller.
module tb_instruction_fetch_controller;

   localparam logic [31:0] BASE = 32'h0040_0000;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   instruction_fetch_controller_if #(.DATA_WIDTH(32)) bus ();

   instruction_fetch_controller #(
      .DATA_WIDTH  (32),
      .MEMORY_DEPTH(32),
      .TEXT_BASE   (BASE),
      .RESET_PC    (BASE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // ROM contents: word k holds 0x10000000 + k; anything outside returns junk.
   function automatic logic [31:0] rom_word(input logic [31:0] off);
      if (off < 32'd128) return 32'h1000_0000 + (off >> 2);
      return 32'hBAD0_0000 ^ off;
   endfunction

   assign bus.pm_instruction_i = rom_word(bus.pm_address_o);

   function automatic bit fetch_ok(input logic [31:0] pc);
      logic [31:0] off;
      off = pc - BASE;
      return (pc % 4 == 0) && (off < 32'd128);
   endfunction

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   item_t exp_q[$];
   int    tests = 0;
   int    fails = 0;

   // Reference model state (transaction level).
   logic [31:0] m_pc      = BASE;
   int          m_count   = 0;
   bit          m_fault   = 1'b0;
   bit          m_started = 1'b0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Model: advances once per clock edge from the spec rules, pushing expected items.
   task automatic model_step();
      int left;
      if (!reset) begin
         m_pc      = BASE;
         m_count   = 0;
         m_fault   = 1'b0;
         m_started = 1'b0;
         exp_q.delete();
      end else if (!m_started) begin
         m_started = 1'b1;
      end else if (bus.redirect_i) begin
         m_count = 0;
         m_pc    = bus.redirect_pc_i;
         m_fault = 1'b0;
         exp_q.delete();
      end else begin
         left = m_count - ((m_count > 0 && bus.instr_ready_i) ? 1 : 0);
         if (!m_fault && left < 2) begin
            if (fetch_ok(m_pc)) begin
               exp_q.push_back('{pc: m_pc, instr: 32'h1000_0000 + ((m_pc - BASE) >> 2)});
               m_pc = m_pc + 32'd4;
               left++;
            end else begin
               m_fault = 1'b1;
            end
         end
         m_count = left;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge reset);
      model_step();
   end

   // Monitor: checks status every cycle and pops the scoreboard on each accepted handshake.
   initial forever begin
      item_t it;
      @(negedge clk);
      if (reset) begin
         check32("valid", {31'd0, bus.instr_valid_o}, {31'd0, m_count != 0});
         check32("fault", {31'd0, bus.fault_o}, {31'd0, m_fault});
         check32("pm_address", bus.pm_address_o, m_pc - BASE);
         if (bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL pop_empty: got pc %h expected no entry at %0t", bus.pc_o, $time);
            end else begin
               it = exp_q.pop_front();
               check32("pc_o", bus.pc_o, it.pc);
               check32("instr_o", bus.instr_o, it.instr);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int r;
      bus.instr_ready_i = 1'b1;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = '0;
      step(3);
      check32("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
      check32("rst_instr", bus.instr_o, 32'd0);
      reset = 1'b1;
      step(12);

      // Back-pressure: FIFO fills, then drains without gap or duplicate.
      bus.instr_ready_i = 1'b0;
      step(6);
      bus.instr_ready_i = 1'b1;
      step(4);

      // Redirect while full.
      bus.instr_ready_i = 1'b0;
      step(3);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = BASE + 32'h40;
      step(1);
      check32("redir_valid", {31'd0, bus.instr_valid_o}, 32'd0);
      bus.redirect_i    = 1'b0;
      bus.instr_ready_i = 1'b1;
      step(1);
      check32("redir_pc", bus.pc_o, BASE + 32'h40);
      check32("redir_instr", bus.instr_o, 32'h1000_0010);
      step(4);

      // Run off the end of the ROM, then recover.
      step(40);
      check32("end_fault", {31'd0, bus.fault_o}, 32'd1);
      check32("end_drained", {31'd0, bus.instr_valid_o}, 32'd0);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = BASE;
      step(1);
      bus.redirect_i = 1'b0;
      check32("recover_fault", {31'd0, bus.fault_o}, 32'd0);
      step(5);

      // Misaligned target, then asynchronous reset mid-cycle.
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = BASE + 32'h2;
      step(1);
      bus.redirect_i = 1'b0;
      step(3);
      check32("misalign_fault", {31'd0, bus.fault_o}, 32'd1);
      #3 reset = 1'b0;
      #1;
      check32("async_instr", bus.instr_o, 32'd0);
      check32("async_pc", bus.pc_o, 32'd0);
      check32("async_valid", {31'd0, bus.instr_valid_o}, 32'd0);
      check32("async_fault", {31'd0, bus.fault_o}, 32'd0);
      check32("async_addr", bus.pm_address_o, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Redirect together with a pop at count=1.
      step(4);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = BASE + 32'h20;
      step(1);
      bus.redirect_i = 1'b0;
      step(2);
      step(4);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         bus.instr_ready_i = ($urandom_range(0, 3) != 0);
         bus.redirect_i    = ($urandom_range(0, 24) == 0);
         r = $urandom_range(0, 9);
         if (r < 7)       bus.redirect_pc_i = BASE + 32'(4 * $urandom_range(0, 31));
         else if (r == 7) bus.redirect_pc_i = BASE + 32'(4 * $urandom_range(28, 40));
         else if (r == 8) bus.redirect_pc_i = BASE + 32'($urandom_range(0, 127));
         else             bus.redirect_pc_i = $urandom;
         step(1);
      end
      bus.redirect_i = 1'b0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
      $finish;
   end

endmodule
